// File: rtl/kf8259_acknowledge_sequencer_pkg.sv
// kf8259_acknowledge_sequencer_pkg: shared types and helpers for the KF8259 acknowledge sequencer.
//   ack_state_t       INTA sequence state (IDLE, ACK1, ACK2, ACK3)
//   CALL_OPCODE       8080 CALL instruction byte driven on the first INTA pulse
//   one_hot_to_level  one-hot IR mask -> 3-bit level number
package KF8259_Common_Package;
    typedef enum logic [1:0] {IDLE, ACK1, ACK2, ACK3} ack_state_t;
    localparam logic [7:0] CALL_OPCODE = 8'hCD;
    function automatic logic [2:0] one_hot_to_level(input logic [7:0] one_hot);
        logic [2:0] level;
        level = 3'd0;
        for (int i = 0; i < 8; i++)
            if (one_hot[i]) level = 3'(i);
        return level;
    endfunction
endpackage

// File: rtl/kf8259_acknowledge_sequencer_if.sv
// kf8259_acknowledge_sequencer_if: CPU-side INTA/read handshake and data bus of the acknowledge sequencer.
//   interrupt_acknowledge_n  INTA pin, active low (master drives)
//   read_strobe              one-cycle CPU read strobe (master drives)
//   interrupt_to_cpu         INT pin (slave drives)
//   data_out/data_out_enable bus byte and its drive enable (slave drives)
interface kf8259_acknowledge_sequencer_if;
    logic       interrupt_acknowledge_n;
    logic       read_strobe;
    logic       interrupt_to_cpu;
    logic [7:0] data_out;
    logic       data_out_enable;
    modport master(output interrupt_acknowledge_n, read_strobe, input interrupt_to_cpu, data_out, data_out_enable);
    modport slave(input interrupt_acknowledge_n, read_strobe, output interrupt_to_cpu, data_out, data_out_enable);
endinterface

// File: rtl/kf8259_acknowledge_sequencer_ocw2.sv
// kf8259_ocw2_decoder: combinational OCW2 decode into an ISR clear mask and a priority-rotation update.
//   in : ocw2_valid/eoi/specific/rotate, ocw2_level, highest_level_in_service
//   out: eoi_mask (ISR bits to clear), rotate_valid/rotate_level (new lowest-priority level)
module kf8259_ocw2_decoder
    import KF8259_Common_Package::*;
(
    input  logic       ocw2_valid,
    input  logic       ocw2_eoi,
    input  logic       ocw2_specific,
    input  logic       ocw2_rotate,
    input  logic [2:0] ocw2_level,
    input  logic [7:0] highest_level_in_service,
    output logic [7:0] eoi_mask,
    output logic       rotate_valid,
    output logic [2:0] rotate_level
);
    logic [7:0] cleared;
    always_comb begin
        cleared      = ocw2_specific ? 8'd1 << ocw2_level : highest_level_in_service;
        eoi_mask     = (ocw2_valid & ocw2_eoi) ? cleared : 8'h00;
        // EOI forms rotate only when something was cleared; R,SL without EOI sets the level directly
        rotate_valid = ocw2_valid & ocw2_rotate & (ocw2_eoi ? |cleared : ocw2_specific);
        rotate_level = (ocw2_eoi & ~ocw2_specific) ? one_hot_to_level(highest_level_in_service) : ocw2_level;
    end
endmodule

// File: rtl/kf8259_acknowledge_sequencer.sv
// kf8259_acknowledge_sequencer: INT generation, 8086/8080 INTA sequencing with vector bytes, AEOI and OCW2 EOI/rotation.
//   clock, reset_n (async, active low); bus (slave modport): INTA_n, read_strobe, INT, data_out/data_out_enable
//   config: mode_8086, auto_eoi_config, rotate_on_auto_eoi, call_interval_4, vector_low_config, vector_high_config
//   resolver/ISR: interrupt_request, highest_level_in_service; OCW2: ocw2_valid/eoi/specific/rotate/level; poll_command
//   to ISR stage: start_in_service, interrupt, end_of_interrupt, priority_rotate
//   Optional: KF8259_POLL_COMMAND_EN enables the OCW3 poll read word.
module kf8259_acknowledge_sequencer
    import KF8259_Common_Package::*;
#(
    parameter logic [2:0] SPURIOUS_LEVEL = 3'd7
) (
    input  logic       clock,
    input  logic       reset_n,
    kf8259_acknowledge_sequencer_if.slave bus,
    input  logic       mode_8086,
    input  logic       auto_eoi_config,
    input  logic       rotate_on_auto_eoi,
    input  logic       call_interval_4,
    input  logic [7:0] vector_low_config,
    input  logic [7:0] vector_high_config,
    input  logic [7:0] interrupt_request,
    input  logic [7:0] highest_level_in_service,
    input  logic       ocw2_valid,
    input  logic       ocw2_eoi,
    input  logic       ocw2_specific,
    input  logic       ocw2_rotate,
    input  logic [2:0] ocw2_level,
    input  logic       poll_command,
    output logic       start_in_service,
    output logic [7:0] interrupt,
    output logic [7:0] end_of_interrupt,
    output logic [2:0] priority_rotate
);
    ack_state_t state;
    logic       inta_q, mode_q, fall, rise, last_pulse, auto_eoi_now, driving, poll_read;
    logic [2:0] level, request_level, ocw2_rotate_level;
    logic [7:0] ocw2_mask, vector_byte;
    logic       ocw2_rotate_valid;
    wire        unused_vector_low = ^vector_low_config[4:0];

    kf8259_ocw2_decoder u_ocw2 (
        .ocw2_valid(ocw2_valid),
        .ocw2_eoi(ocw2_eoi),
        .ocw2_specific(ocw2_specific),
        .ocw2_rotate(ocw2_rotate),
        .ocw2_level(ocw2_level),
        .highest_level_in_service(highest_level_in_service),
        .eoi_mask(ocw2_mask),
        .rotate_valid(ocw2_rotate_valid),
        .rotate_level(ocw2_rotate_level)
    );

`ifdef KF8259_POLL_COMMAND_EN
    logic poll_pending;
    always_ff @(posedge clock or negedge reset_n)
        if (!reset_n) poll_pending <= 1'b0;
        else          poll_pending <= poll_command | (poll_pending & ~bus.read_strobe);
    assign poll_read = poll_pending & bus.read_strobe;
`else
    wire unused_poll = poll_command ^ bus.read_strobe;
    assign poll_read = 1'b0;
`endif

    always_comb begin
        request_level = |interrupt_request ? one_hot_to_level(interrupt_request) : SPURIOUS_LEVEL;
        fall          = inta_q & ~bus.interrupt_acknowledge_n;
        rise          = ~inta_q & bus.interrupt_acknowledge_n;
        last_pulse    = (state == ACK3) | ((state == ACK2) & mode_q);
        auto_eoi_now  = last_pulse & rise & auto_eoi_config;
        vector_byte   = (state == ACK1) ? CALL_OPCODE
                      : (state == ACK3) ? vector_high_config
                      : mode_q          ? {vector_high_config[7:3], level}
                      : call_interval_4 ? {vector_low_config[7:5], level, 2'b00}
                      :                   {vector_low_config[7:6], level, 3'b000};
        // inta_q low as well keeps the bus quiet on the edge cycle, before state has advanced to the new pulse
        driving       = (state != IDLE) & ~((state == ACK1) & mode_q) & ~bus.interrupt_acknowledge_n & ~inta_q;
        bus.data_out_enable = driving | poll_read;
        bus.data_out  = poll_read ? {|interrupt_request, 4'b0000, request_level}
                      : driving   ? vector_byte : 8'h00;
    end

    always_ff @(posedge clock or negedge reset_n)
        if (!reset_n) begin
            state                <= IDLE;
            inta_q               <= 1'b1;
            mode_q               <= 1'b0;
            level                <= 3'd0;
            interrupt            <= 8'h00;
            start_in_service     <= 1'b0;
            end_of_interrupt     <= 8'h00;
            priority_rotate      <= 3'd7;
            bus.interrupt_to_cpu <= 1'b0;
        end else begin
            inta_q               <= bus.interrupt_acknowledge_n;
            start_in_service     <= 1'b0;
            end_of_interrupt     <= ocw2_mask | (auto_eoi_now ? interrupt : 8'h00);
            bus.interrupt_to_cpu <= (state == IDLE) & ~fall & |interrupt_request;
            if (ocw2_rotate_valid)
                priority_rotate <= ocw2_rotate_level;
            else if (auto_eoi_now & rotate_on_auto_eoi & |interrupt)
                priority_rotate <= level;
            if (((state == IDLE) & fall) | poll_read) begin
                interrupt        <= interrupt_request;
                level            <= request_level;
                start_in_service <= 1'b1;
            end
            if ((state == IDLE) & fall) begin
                state  <= ACK1;
                mode_q <= mode_8086;
            end else if ((state == ACK1) & fall)
                state <= ACK2;
            else if ((state == ACK2) & fall & ~mode_q)
                state <= ACK3;
            else if (last_pulse & rise)
                state <= IDLE;
        end
endmodule

// File: tb/tb_kf8259_acknowledge_sequencer.sv
// tb_kf8259_acknowledge_sequencer: self-checking bench for the KF8259 acknowledge sequencer (poll word with KF8259_POLL_COMMAND_EN).
module tb_kf8259_acknowledge_sequencer;
    logic       clock = 1'b0;
    logic       reset_n;
    logic       mode_8086, auto_eoi_config, rotate_on_auto_eoi, call_interval_4;
    logic [7:0] vector_low_config, vector_high_config, interrupt_request, highest_level_in_service;
    logic       ocw2_valid, ocw2_eoi, ocw2_specific, ocw2_rotate;
    logic [2:0] ocw2_level;
    logic       poll_command;
    logic       start_in_service;
    logic [7:0] interrupt, end_of_interrupt;
    logic [2:0] priority_rotate;
    int         vectors = 0, miscompares = 0;
    logic [7:0] exp_q[$];
    logic [7:0] exp, got, eoi;
    int         en, sis;

    kf8259_acknowledge_sequencer_if bus ();

    kf8259_acknowledge_sequencer #(.SPURIOUS_LEVEL(3'd7)) dut (
        .clock(clock),
        .reset_n(reset_n),
        .bus(bus.slave),
        .mode_8086(mode_8086),
        .auto_eoi_config(auto_eoi_config),
        .rotate_on_auto_eoi(rotate_on_auto_eoi),
        .call_interval_4(call_interval_4),
        .vector_low_config(vector_low_config),
        .vector_high_config(vector_high_config),
        .interrupt_request(interrupt_request),
        .highest_level_in_service(highest_level_in_service),
        .ocw2_valid(ocw2_valid),
        .ocw2_eoi(ocw2_eoi),
        .ocw2_specific(ocw2_specific),
        .ocw2_rotate(ocw2_rotate),
        .ocw2_level(ocw2_level),
        .poll_command(poll_command),
        .start_in_service(start_in_service),
        .interrupt(interrupt),
        .end_of_interrupt(end_of_interrupt),
        .priority_rotate(priority_rotate)
    );

    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // One INTA pulse: 4 cycles low, 4 high; records enabled bus byte, start_in_service and EOI activity.
    task automatic pulse(output int en_cnt, output logic [7:0] byte_seen, output int sis_cnt, output logic [7:0] eoi_seen);
        en_cnt = 0;
        byte_seen = 8'h00;
        sis_cnt = 0;
        eoi_seen = 8'h00;
        bus.interrupt_acknowledge_n = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (i == 4) bus.interrupt_acknowledge_n = 1'b1;
            @(negedge clock);
            sis_cnt += int'(start_in_service);
            eoi_seen |= end_of_interrupt;
            if (bus.data_out_enable) begin
                en_cnt++;
                byte_seen = bus.data_out;
            end
            step();
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) step();
        reset_n = 1'b1;
        step();
        vectors++; if (bus.interrupt_to_cpu !== 1'b0) begin miscompares++; $display("FAIL reset_int: got %b expected 0", bus.interrupt_to_cpu); end
        vectors++; if (start_in_service !== 1'b0) begin miscompares++; $display("FAIL reset_sis: got %b expected 0", start_in_service); end
        vectors++; if (interrupt !== 8'h00) begin miscompares++; $display("FAIL reset_interrupt: got %h expected 00", interrupt); end
        vectors++; if (end_of_interrupt !== 8'h00) begin miscompares++; $display("FAIL reset_eoi: got %h expected 00", end_of_interrupt); end
        vectors++; if (priority_rotate !== 3'd7) begin miscompares++; $display("FAIL reset_rotate: got %0d expected 7", priority_rotate); end
        vectors++; if (bus.data_out_enable !== 1'b0 || bus.data_out !== 8'h00) begin miscompares++; $display("FAIL reset_bus: got en=%b data=%h expected 0/00", bus.data_out_enable, bus.data_out); end
    endtask

    task automatic test_8086_basic();
        mode_8086 = 1'b1;
        vector_high_config = 8'h40;
        interrupt_request = 8'h08;
        step();
        vectors++; if (bus.interrupt_to_cpu !== 1'b1) begin miscompares++; $display("FAIL int_raise: got %b expected 1", bus.interrupt_to_cpu); end
        exp_q.push_back(8'h43);
        pulse(en, got, sis, eoi);
        vectors++; if (en != 0) begin miscompares++; $display("FAIL 8086_pulse1_quiet: got %0d driven cycles expected 0", en); end
        vectors++; if (sis != 1) begin miscompares++; $display("FAIL 8086_sis: got %0d pulses expected 1", sis); end
        vectors++; if (interrupt !== 8'h08) begin miscompares++; $display("FAIL 8086_interrupt: got %h expected 08", interrupt); end
        vectors++; if (bus.interrupt_to_cpu !== 1'b0) begin miscompares++; $display("FAIL int_drop: got %b expected 0", bus.interrupt_to_cpu); end
        pulse(en, got, sis, eoi);
        exp = exp_q.pop_front();
        vectors++; if (en == 0 || got !== exp) begin miscompares++; $display("FAIL 8086_vector: got %h (%0d cycles) expected %h", got, en, exp); end
        vectors++; if (eoi !== 8'h00) begin miscompares++; $display("FAIL 8086_no_aeoi: got %h expected 00", eoi); end
        vectors++; if (bus.interrupt_to_cpu !== 1'b1) begin miscompares++; $display("FAIL int_reeval: got %b expected 1", bus.interrupt_to_cpu); end
        interrupt_request = 8'h00;
        step();
    endtask

    task automatic test_8080(input logic interval4, input logic [7:0] mid_byte);
        mode_8086 = 1'b0;
        call_interval_4 = interval4;
        vector_low_config = 8'hA0;
        vector_high_config = 8'h12;
        interrupt_request = 8'h04;
        step();
        exp_q.push_back(8'hCD);
        exp_q.push_back(mid_byte);
        exp_q.push_back(8'h12);
        for (int p = 0; p < 3; p++) begin
            pulse(en, got, sis, eoi);
            exp = exp_q.pop_front();
            vectors++; if (en == 0 || got !== exp) begin miscompares++; $display("FAIL 8080_byte%0d: got %h (%0d cycles) expected %h", p, got, en, exp); end
        end
        interrupt_request = 8'h00;
        step();
    endtask

    task automatic test_aeoi_rotate();
        mode_8086 = 1'b1;
        auto_eoi_config = 1'b1;
        rotate_on_auto_eoi = 1'b1;
        vector_high_config = 8'h40;
        interrupt_request = 8'h20;
        step();
        exp_q.push_back(8'h45);
        pulse(en, got, sis, eoi);
        vectors++; if (eoi !== 8'h00) begin miscompares++; $display("FAIL aeoi_early: got %h expected 00", eoi); end
        pulse(en, got, sis, eoi);
        exp = exp_q.pop_front();
        vectors++; if (en == 0 || got !== exp) begin miscompares++; $display("FAIL aeoi_vector: got %h expected %h", got, exp); end
        vectors++; if (eoi !== 8'h20) begin miscompares++; $display("FAIL aeoi_eoi: got %h expected 20", eoi); end
        vectors++; if (priority_rotate !== 3'd5) begin miscompares++; $display("FAIL aeoi_rotate: got %0d expected 5", priority_rotate); end
        auto_eoi_config = 1'b0;
        rotate_on_auto_eoi = 1'b0;
        interrupt_request = 8'h00;
        step();
    endtask

    task automatic test_spurious();
        mode_8086 = 1'b1;
        vector_high_config = 8'h40;
        interrupt_request = 8'h00;
        step();
        exp_q.push_back(8'h47);
        pulse(en, got, sis, eoi);
        vectors++; if (interrupt !== 8'h00) begin miscompares++; $display("FAIL spurious_interrupt: got %h expected 00", interrupt); end
        pulse(en, got, sis, eoi);
        exp = exp_q.pop_front();
        vectors++; if (en == 0 || got !== exp) begin miscompares++; $display("FAIL spurious_vector: got %h expected %h", got, exp); end
    endtask

    task automatic test_ocw2();
        highest_level_in_service = 8'h10;
        {ocw2_valid, ocw2_eoi, ocw2_specific, ocw2_rotate} = 4'b1100;
        step();
        ocw2_valid = 1'b0;
        vectors++; if (end_of_interrupt !== 8'h10) begin miscompares++; $display("FAIL ns_eoi: got %h expected 10", end_of_interrupt); end
        step();
        vectors++; if (end_of_interrupt !== 8'h00) begin miscompares++; $display("FAIL eoi_one_cycle: got %h expected 00", end_of_interrupt); end
        {ocw2_valid, ocw2_eoi, ocw2_specific, ocw2_rotate} = 4'b1111;
        ocw2_level = 3'd6;
        step();
        ocw2_valid = 1'b0;
        vectors++; if (end_of_interrupt !== 8'h40) begin miscompares++; $display("FAIL sp_eoi: got %h expected 40", end_of_interrupt); end
        vectors++; if (priority_rotate !== 3'd6) begin miscompares++; $display("FAIL sp_rotate: got %0d expected 6", priority_rotate); end
        {ocw2_valid, ocw2_eoi, ocw2_specific, ocw2_rotate} = 4'b1011;
        ocw2_level = 3'd2;
        step();
        ocw2_valid = 1'b0;
        vectors++; if (end_of_interrupt !== 8'h00 || priority_rotate !== 3'd2) begin miscompares++; $display("FAIL set_priority: got eoi=%h rot=%0d expected 00/2", end_of_interrupt, priority_rotate); end
        highest_level_in_service = 8'h00;
        {ocw2_valid, ocw2_eoi, ocw2_specific, ocw2_rotate} = 4'b1101;
        step();
        ocw2_valid = 1'b0;
        vectors++; if (end_of_interrupt !== 8'h00 || priority_rotate !== 3'd2) begin miscompares++; $display("FAIL empty_eoi: got eoi=%h rot=%0d expected 00/2", end_of_interrupt, priority_rotate); end
        step();
    endtask

    task automatic test_reset_mid_ack2();
        mode_8086 = 1'b1;
        auto_eoi_config = 1'b1;
        vector_high_config = 8'h40;
        interrupt_request = 8'h08;
        step();
        pulse(en, got, sis, eoi);
        bus.interrupt_acknowledge_n = 1'b0;
        step();
        step();
        vectors++; if (bus.data_out_enable !== 1'b1 || bus.data_out !== 8'h43) begin miscompares++; $display("FAIL ack2_drive: got en=%b data=%h expected 1/43", bus.data_out_enable, bus.data_out); end
        reset_n = 1'b0;
        #1;
        vectors++; if (bus.data_out_enable !== 1'b0 || interrupt !== 8'h00 || bus.interrupt_to_cpu !== 1'b0 || priority_rotate !== 3'd7) begin
            miscompares++; $display("FAIL mid_reset_outputs: got en=%b irq=%h int=%b rot=%0d expected 0/00/0/7", bus.data_out_enable, interrupt, bus.interrupt_to_cpu, priority_rotate);
        end
        bus.interrupt_acknowledge_n = 1'b1;
        step();
        reset_n = 1'b1;
        eoi = 8'h00;
        for (int i = 0; i < 3; i++) begin
            step();
            eoi |= end_of_interrupt;
        end
        vectors++; if (eoi !== 8'h00) begin miscompares++; $display("FAIL mid_reset_no_eoi: got %h expected 00", eoi); end
        vectors++; if (bus.interrupt_to_cpu !== 1'b1) begin miscompares++; $display("FAIL mid_reset_idle: got int=%b expected 1", bus.interrupt_to_cpu); end
        auto_eoi_config = 1'b0;
        interrupt_request = 8'h00;
        step();
    endtask

    task automatic test_poll();
        interrupt_request = 8'h02;
        poll_command = 1'b1;
        step();
        poll_command = 1'b0;
        bus.read_strobe = 1'b1;
        @(negedge clock);
`ifdef KF8259_POLL_COMMAND_EN
        vectors++; if (bus.data_out_enable !== 1'b1 || bus.data_out !== 8'h81) begin miscompares++; $display("FAIL poll_word: got en=%b data=%h expected 1/81", bus.data_out_enable, bus.data_out); end
        step();
        bus.read_strobe = 1'b0;
        vectors++; if (start_in_service !== 1'b1 || interrupt !== 8'h02) begin miscompares++; $display("FAIL poll_sis: got sis=%b irq=%h expected 1/02", start_in_service, interrupt); end
`else
        vectors++; if (bus.data_out_enable !== 1'b0) begin miscompares++; $display("FAIL poll_ignored: got en=%b expected 0", bus.data_out_enable); end
        step();
        bus.read_strobe = 1'b0;
        vectors++; if (start_in_service !== 1'b0) begin miscompares++; $display("FAIL poll_no_sis: got %b expected 0", start_in_service); end
`endif
        interrupt_request = 8'h00;
        step();
    endtask

    initial begin
        reset_n = 1'b0;
        bus.interrupt_acknowledge_n = 1'b1;
        bus.read_strobe = 1'b0;
        mode_8086 = 1'b1;
        auto_eoi_config = 1'b0;
        rotate_on_auto_eoi = 1'b0;
        call_interval_4 = 1'b1;
        vector_low_config = 8'h00;
        vector_high_config = 8'h00;
        interrupt_request = 8'h00;
        highest_level_in_service = 8'h00;
        {ocw2_valid, ocw2_eoi, ocw2_specific, ocw2_rotate} = 4'b0000;
        ocw2_level = 3'd0;
        poll_command = 1'b0;
        test_reset();
        test_8086_basic();
        test_8080(1'b1, 8'hA8);
        test_8080(1'b0, 8'h90);
        test_aeoi_rotate();
        test_spurious();
        test_ocw2();
        test_reset_mid_ack2();
        test_poll();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
